// File: rtl/edu_token_collect.sv
// EDU token row receive side: recovers (token_exist, token_col) from the
// one-hot token / thermometer flag vector pair and checks their consistency.
module edu_token_collect #(
   parameter int NUM_AQROW    = 16,
   parameter int AQROWADDR_BW = 4,
   parameter int ERRCNT_BW    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_AQROW-1:0]    token_set_in,
   input  logic [NUM_AQROW-1:0]    flag_set_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    token_exist_out,
   output logic [AQROWADDR_BW-1:0] token_col_out,
   output logic                    err_multi,
   output logic                    err_flag,
   output logic [ERRCNT_BW-1:0]    err_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      OUT    = 2'd2
   } state_t;

   localparam logic [NUM_AQROW-1:0] ONE  = NUM_AQROW'(1);
   localparam logic [ERRCNT_BW-1:0] CONE = ERRCNT_BW'(1);

   state_t                  state_q, state_d;
   logic                    live_q;
   logic [NUM_AQROW-1:0]    tok_q, tok_d;
   logic [NUM_AQROW-1:0]    flg_q, flg_d;
   logic                    exist_q, exist_d;
   logic [AQROWADDR_BW-1:0] col_q, col_d;
   logic                    multi_q, multi_d;
   logic                    flerr_q, flerr_d;
   logic [ERRCNT_BW-1:0]    cnt_q, cnt_d;

   logic                    dec_exist;
   logic                    dec_multi;
   logic                    dec_flerr;
   logic [AQROWADDR_BW-1:0] dec_col;
   logic [NUM_AQROW-1:0]    dec_low;
   logic [NUM_AQROW-1:0]    dec_exp;

   // Lowest set bit isolates the token; low|(low-1) is its thermometer.
   always_comb begin
      dec_low   = tok_q & (~tok_q + ONE);
      dec_exist = |tok_q;
      dec_multi = (tok_q & (tok_q - ONE)) != '0;
      dec_col   = '0;
      for (int i = NUM_AQROW - 1; i >= 0; i--) begin
         if (tok_q[i]) dec_col = AQROWADDR_BW'(i);
      end
      dec_exp   = dec_exist ? (dec_low | (dec_low - ONE)) : '0;
      dec_flerr = flg_q != dec_exp;
   end

   always_comb begin
      state_d = state_q;
      tok_d   = tok_q;
      flg_d   = flg_q;
      exist_d = exist_q;
      col_d   = col_q;
      multi_d = multi_q;
      flerr_d = flerr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && live_q) begin
               tok_d   = token_set_in;
               flg_d   = flag_set_in;
               state_d = DECODE;
            end
         end
         DECODE: begin
            exist_d = dec_exist;
            col_d   = dec_col;
            multi_d = dec_multi;
            flerr_d = dec_flerr;
            if ((dec_multi || dec_flerr) && cnt_q != '1) begin
               cnt_d = cnt_q + CONE;
            end
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               multi_d = 1'b0;
               flerr_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // live_q keeps in_ready low while reset is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         live_q  <= 1'b0;
         tok_q   <= '0;
         flg_q   <= '0;
         exist_q <= 1'b0;
         col_q   <= '0;
         multi_q <= 1'b0;
         flerr_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
         tok_q   <= tok_d;
         flg_q   <= flg_d;
         exist_q <= exist_d;
         col_q   <= col_d;
         multi_q <= multi_d;
         flerr_q <= flerr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready        = live_q && (state_q == IDLE);
   assign out_valid       = (state_q == OUT);
   assign token_exist_out = exist_q;
   assign token_col_out   = col_q;
   assign err_multi       = multi_q;
   assign err_flag        = flerr_q;
   assign err_cnt         = cnt_q;

endmodule
